// File: rtl/oam_dma_pkg.sv
// Shared PPU-side definitions for the OAM DMA engine.
//   oam_dma_state_t : DMA controller state encoding
//   OAM_BYTES       : bytes copied by one DMA transfer
//   OAM_WORDS       : 16-bit words in the OAM RAM
//   dma_eff_page()  : folds echo-RAM pages E0..FF back onto C0..DF
package oam_dma_pkg;

   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_START = 2'd1,
      DMA_XFER  = 2'd2,
      DMA_FLUSH = 2'd3
   } oam_dma_state_t;

   localparam int OAM_BYTES = 160;
   localparam int OAM_WORDS = 80;

   // Pages E0..FF mirror work RAM, so the DMA reads the mirrored page instead.
   function automatic logic [7:0] dma_eff_page(input logic [7:0] page);
      if (page >= 8'hE0) begin
         return page - 8'h20;
      end
      return page;
   endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: on a CPU write to $FF46, copies BYTES source bytes from
// page {reg_d_wr, 8'h00} into OAM, packing byte pairs into 16-bit words.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// DMA_IDLE  | no transfer; waiting for a $FF46 write
// DMA_START | one-byte-slot setup delay, bus owned but not read
// DMA_XFER  | one byte read per slot; odd bytes complete an OAM word
// DMA_FLUSH | carries the final word write, then releases the bus
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   reset        in   synchronous active-high reset
//   reg_write    in   CPU write strobe for $FF46 (starts/restarts a transfer)
//   reg_d_wr     in   source page written by the CPU
//   reg_d_rd     out  last value written to $FF46
//   dma_active   out  transfer in progress (bus and OAM port owned)
//   dma_src_addr out  source byte address, 0 outside XFER
//   dma_d_in     in   source byte data
//   oam_addr     out  OAM word address
//   oam_d_wr     out  OAM word, even byte low, odd byte high
//   oam_write    out  one-cycle OAM write strobe
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int BYTES           = OAM_BYTES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_write,
   input  logic [7:0]  reg_d_wr,
   output logic [7:0]  reg_d_rd,
   output logic        dma_active,
   output logic [15:0] dma_src_addr,
   input  logic [7:0]  dma_d_in,
   output logic [6:0]  oam_addr,
   output logic [15:0] oam_d_wr,
   output logic        oam_write
);

   localparam int              PW       = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
   localparam logic [PW-1:0]   PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
   localparam logic [7:0]      IDX_LAST = 8'(BYTES - 1);

   oam_dma_state_t r_state;
   oam_dma_state_t w_state_nxt;

   logic [PW-1:0] r_phase;
   logic [7:0]    r_idx;
   logic [7:0]    r_page;
   logic [7:0]    r_reg_d_rd;
   logic [7:0]    r_low;
   logic [6:0]    r_oam_addr;
   logic [15:0]   r_oam_d_wr;
   logic          r_oam_write;

   logic          w_last_phase;
   logic          w_last_byte;
   logic [7:0]    w_eff_page;

   assign w_last_phase = (r_phase == PH_LAST);
   assign w_last_byte  = (r_idx == IDX_LAST);
   assign w_eff_page   = dma_eff_page(r_page);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= DMA_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A $FF46 write wins in every state, so a restart never drops dma_active.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DMA_IDLE: begin
            if (reg_write) begin
               w_state_nxt = DMA_START;
            end
         end
         DMA_START: begin
            if (reg_write) begin
               w_state_nxt = DMA_START;
            end else if (w_last_phase) begin
               w_state_nxt = DMA_XFER;
            end
         end
         DMA_XFER: begin
            if (reg_write) begin
               w_state_nxt = DMA_START;
            end else if (w_last_phase && w_last_byte) begin
               w_state_nxt = DMA_FLUSH;
            end
         end
         DMA_FLUSH: begin
            if (reg_write) begin
               w_state_nxt = DMA_START;
            end else begin
               w_state_nxt = DMA_IDLE;
            end
         end
         default: begin
            w_state_nxt = DMA_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase     <= '0;
         r_idx       <= 8'd0;
         r_page      <= 8'd0;
         r_reg_d_rd  <= 8'd0;
         r_low       <= 8'd0;
         r_oam_addr  <= 7'd0;
         r_oam_d_wr  <= 16'd0;
         r_oam_write <= 1'b0;
      end else begin
         r_oam_write <= 1'b0;
         if (reg_write) begin
            // Restart: any half-built word is abandoned along with the old page.
            r_page     <= reg_d_wr;
            r_reg_d_rd <= reg_d_wr;
            r_idx      <= 8'd0;
            r_phase    <= '0;
            r_low      <= 8'd0;
         end else begin
            case (r_state)
               DMA_START: begin
                  r_phase <= w_last_phase ? '0 : r_phase + PW'(1);
               end
               DMA_XFER: begin
                  r_phase <= w_last_phase ? '0 : r_phase + PW'(1);
                  // Data is taken at the end of the slot so the source has
                  // the whole slot minus one cycle to respond.
                  if (w_last_phase) begin
                     if (!r_idx[0]) begin
                        r_low <= dma_d_in;
                     end else begin
                        r_oam_d_wr  <= {dma_d_in, r_low};
                        r_oam_addr  <= r_idx[7:1];
                        r_oam_write <= 1'b1;
                     end
                     if (!w_last_byte) begin
                        r_idx <= r_idx + 8'd1;
                     end
                  end
               end
               default: begin
                  r_phase <= '0;
               end
            endcase
         end
      end
   end

   assign reg_d_rd     = r_reg_d_rd;
   assign dma_active   = (r_state != DMA_IDLE);
   assign dma_src_addr = (r_state == DMA_XFER) ? {w_eff_page, r_idx} : 16'h0000;
   assign oam_addr     = r_oam_addr;
   assign oam_d_wr     = r_oam_d_wr;
   assign oam_write    = r_oam_write;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rw0, rw1;
   logic [7:0]  wd0, wd1, rd0, rd1, din0, din1;
   logic        act0, act1, ow0, ow1;
   logic [15:0] src0, src1, dw0, dw1;
   logic [6:0]  oa0, oa1;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] mem [0:65535];

   // Behavioural model state, per instance: transfer start edge, page, etc.
   int          m_t  [2];
   logic        m_on [2];
   logic [7:0]  m_pg [2];
   logic [7:0]  m_rd [2];
   logic [6:0]  m_la [2];
   logic [15:0] m_ld [2];

   always #5 clk = ~clk;

   oam_dma #(.CYCLES_PER_BYTE(4), .BYTES(160)) u_dut0 (
      .clk(clk), .reset(reset), .reg_write(rw0), .reg_d_wr(wd0), .reg_d_rd(rd0),
      .dma_active(act0), .dma_src_addr(src0), .dma_d_in(din0),
      .oam_addr(oa0), .oam_d_wr(dw0), .oam_write(ow0));

   oam_dma #(.CYCLES_PER_BYTE(2), .BYTES(8)) u_dut1 (
      .clk(clk), .reset(reset), .reg_write(rw1), .reg_d_wr(wd1), .reg_d_rd(rd1),
      .dma_active(act1), .dma_src_addr(src1), .dma_d_in(din1),
      .oam_addr(oa1), .oam_d_wr(dw1), .oam_write(ow1));

   // Source memory: synchronous read, one-cycle latency.
   always @(posedge clk) begin
      din0 <= mem[src0];
      din1 <= mem[src1];
      cyc  <= cyc + 1;
   end

   function automatic logic [7:0] tb_eff(input logic [7:0] p);
      if (p >= 8'hE0) return p - 8'h20;
      return p;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc + 1, got, exp);
      end
   endtask

   // Spec cycle number of the current period is cyc+1 (period after edge cyc).
   task automatic wait_cycle(input int c);
      while (cyc + 1 < c) @(negedge clk);
   endtask

   task automatic start(input int n, input logic [7:0] page);
      if (n == 0) begin rw0 = 1'b1; wd0 = page; end
      else        begin rw1 = 1'b1; wd1 = page; end
      @(posedge clk);
      #1;
      rw0 = 1'b0;
      rw1 = 1'b0;
      m_t[n]  = cyc;
      m_on[n] = 1'b1;
      m_pg[n] = page;
      m_rd[n] = page;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int n = 0; n < 2; n++) begin
         m_on[n] = 1'b0; m_t[n] = 0; m_pg[n] = 8'h00; m_rd[n] = 8'h00;
         m_la[n] = 7'd0; m_ld[n] = 16'h0000;
      end
   endtask

   // Per-cycle comparison against the timing-rule model.
   int          c_cpb, c_nb, c_rel, c_lim, c_bi, c_k;
   logic [7:0]  c_ep;
   logic        e_act, e_wr;
   logic [15:0] e_src;
   always @(negedge clk) begin
      if (cyc >= 1) begin
         for (int n = 0; n < 2; n++) begin
            c_cpb = (n == 0) ? 4 : 2;
            c_nb  = (n == 0) ? 160 : 8;
            c_rel = cyc + 1 - m_t[n];
            c_lim = c_cpb * (c_nb + 1) + 1;
            c_ep  = tb_eff(m_pg[n]);
            e_act = m_on[n] && c_rel >= 1 && c_rel <= c_lim;
            e_src = 16'h0000;
            if (m_on[n] && c_rel >= c_cpb + 1 && c_rel <= c_cpb * (c_nb + 1)) begin
               c_bi  = (c_rel - c_cpb - 1) / c_cpb;
               e_src = {c_ep, 8'(c_bi)};
            end
            e_wr = 1'b0;
            if (m_on[n] && c_rel >= 3 * c_cpb + 1 && c_rel <= c_lim &&
                ((c_rel - 1) % (2 * c_cpb)) == c_cpb) begin
               c_k     = ((c_rel - 1) / c_cpb - 3) / 2;
               e_wr    = 1'b1;
               m_la[n] = 7'(c_k);
               m_ld[n] = {mem[{c_ep, 8'(2 * c_k + 1)}], mem[{c_ep, 8'(2 * c_k)}]};
            end
            if (n == 0) begin
               chk("u0_active", act0, e_act);
               chk("u0_src", src0, e_src);
               chk("u0_write", ow0, e_wr);
               chk("u0_oam_addr", oa0, m_la[0]);
               chk("u0_oam_data", dw0, m_ld[0]);
               chk("u0_reg_rd", rd0, m_rd[0]);
            end else begin
               chk("u1_active", act1, e_act);
               chk("u1_src", src1, e_src);
               chk("u1_write", ow1, e_wr);
               chk("u1_oam_addr", oa1, m_la[1]);
               chk("u1_oam_data", dw1, m_ld[1]);
               chk("u1_reg_rd", rd1, m_rd[1]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc + 1);
      $fatal(1, "watchdog");
   end

   int t, t2, t3;
   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
      for (int n = 0; n < 2; n++) begin
         m_on[n] = 1'b0; m_t[n] = 0; m_pg[n] = 8'h00; m_rd[n] = 8'h00;
         m_la[n] = 7'd0; m_ld[n] = 16'h0000;
      end
      rw0 = 1'b0; rw1 = 1'b0; wd0 = 8'h00; wd1 = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      wait_cycle(cyc + 3);
      chk("reset_active", act0, 1'b0);
      chk("reset_reg_rd", rd0, 8'h00);
      chk("reset_oam_write", ow0, 1'b0);

      // Basic copy from C0
      start(0, 8'hC0);
      t = m_t[0];
      wait_cycle(t + 4);  chk("start_no_read", src0, 16'h0000);
      wait_cycle(t + 5);  chk("first_addr", src0, 16'hC000);
      wait_cycle(t + 12); chk("no_early_write", ow0, 1'b0);
      wait_cycle(t + 13);
      chk("word0_write", ow0, 1'b1);
      chk("word0_addr", oa0, 7'd0);
      chk("word0_data", dw0, 16'h5B5A);
      wait_cycle(t + 645);
      chk("word79_write", ow0, 1'b1);
      chk("word79_addr", oa0, 7'd79);
      chk("word79_data", dw0, 16'hC5C4);
      chk("last_active", act0, 1'b1);

      // Back-to-back write in the IDLE cycle, then restart with D0
      wait_cycle(t + 646);
      chk("idle_gap", act0, 1'b0);
      start(0, 8'hC0);
      t2 = m_t[0];
      wait_cycle(t2 + 100);
      start(0, 8'hD0);
      t3 = m_t[0];
      wait_cycle(t2 + 101); chk("restart_active", act0, 1'b1);
      wait_cycle(t2 + 113);
      chk("restart_word0_write", ow0, 1'b1);
      chk("restart_word0_data", dw0, 16'h4B4A);
      wait_cycle(t3 + 645); chk("restart_last_active", act0, 1'b1);
      wait_cycle(t3 + 646); chk("restart_done", act0, 1'b0);

      // Echo remap
      wait_cycle(t3 + 648);
      start(0, 8'hE3);
      t = m_t[0];
      wait_cycle(t + 1);   chk("echo_reg_rd", rd0, 8'hE3);
      wait_cycle(t + 5);   chk("echo_e3_first", src0, 16'hC300);
      wait_cycle(t + 644); chk("echo_e3_last", src0, 16'hC39F);
      wait_cycle(t + 650);
      start(0, 8'hFF);
      t = m_t[0];
      wait_cycle(t + 5);   chk("echo_ff_first", src0, 16'hDF00);
      wait_cycle(t + 644); chk("echo_ff_last", src0, 16'hDF9F);

      // Reset mid-transfer
      wait_cycle(t + 650);
      start(0, 8'hC0);
      t = m_t[0];
      wait_cycle(t + 300);
      do_reset();
      wait_cycle(t + 301);
      chk("rst_active", act0, 1'b0);
      chk("rst_oam_write", ow0, 1'b0);
      chk("rst_reg_rd", rd0, 8'h00);
      wait_cycle(t + 340);
      start(0, 8'hC1);
      t = m_t[0];
      wait_cycle(t + 13);  chk("post_rst_word0", dw0, {mem[16'hC101], mem[16'hC100]});
      wait_cycle(t + 648);

      // Parameter sweep instance: CYCLES_PER_BYTE=2, BYTES=8
      start(1, 8'hC0);
      t = m_t[1];
      wait_cycle(t + 7);
      chk("p_word0_write", ow1, 1'b1);
      chk("p_word0_addr", oa1, 7'd0);
      chk("p_word0_data", dw1, 16'h5B5A);
      wait_cycle(t + 19);
      chk("p_word3_write", ow1, 1'b1);
      chk("p_word3_addr", oa1, 7'd3);
      chk("p_last_active", act1, 1'b1);
      wait_cycle(t + 20); chk("p_done", act1, 1'b0);
      start(1, 8'hE5);
      t = m_t[1];
      wait_cycle(t + 10);
      start(1, 8'hD0);
      t = m_t[1];
      wait_cycle(t + 25);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

Copies 160 bytes from a CPU-bus source page into OAM when software writes the DMA register ($FF46). It is the writing side of OAM and the bus master behind the PPU's `dma_src_addr` / `dma_d_in` / `dma_active` ports. While it runs, it owns the CPU bus and the OAM write port. It packs source bytes pairwise into the 16-bit, 80-word OAM RAM.

## Interface
Parameters:
- `CYCLES_PER_BYTE`, default 4: clk cycles per transferred byte (one M-cycle of dots).
- `BYTES`, default 160: transfer length in bytes; must be even.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `reg_write`  in  1  CPU write strobe for $FF46.
- `reg_d_wr`  in  8  source page written by the CPU.
- `reg_d_rd`  out  8  last value written to $FF46.
- `dma_active`  out  1  transfer in progress; the bus arbiter gives the bus to this block.
- `dma_src_addr`  out  16  source byte address.
- `dma_d_in`  in  8  source byte data.
- `oam_addr`  out  7  OAM word address, 0..79.
- `oam_d_wr`  out  16  OAM word: even byte in [7:0], odd byte in [15:8].
- `oam_write`  out  1  one-cycle OAM word write strobe.

## Operation
- **Reset values:** all outputs 0; state IDLE; page, index, phase and holding registers 0.
- **States:** IDLE, START, XFER, FLUSH.
- **IDLE**
  - `reg_write` latches `reg_d_wr` into the page and into `reg_d_rd`.
  - Clears the byte index and phase, then goes to START.
- **START**
  - Waits `CYCLES_PER_BYTE` cycles (phase counter), then goes to XFER.
  - `dma_active` = 1; no bus reads.
- **XFER**
  - Address: `dma_src_addr` = {eff_page, idx}, where eff_page = page − 8'h20 if page ≥ 8'hE0, else page (E0→C0, FF→DF).
  - Sampling: `dma_d_in` is sampled in the last phase of each byte slot.
  - Even idx: the sampled byte goes to the low holding register.
  - Odd idx: the word {`dma_d_in`, low} is registered into `oam_d_wr`, with `oam_addr` = idx>>1. `oam_write` pulses on the next cycle.
  - After sampling idx = `BYTES`−1, go to FLUSH. Otherwise increment idx.
- **FLUSH**
  - One cycle carrying the final `oam_write` pulse, then IDLE.
  - `dma_active` is still 1 during FLUSH.
- **Non-final word writes** occur while still in XFER, in the first phase of the next slot.
- **Restart:** `reg_write` in any non-IDLE state relatches the page and `reg_d_rd`, clears idx and phase, and enters START.
  - `dma_active` stays 1 with no gap.
  - An `oam_write` already registered for that cycle still completes.
  - A half-filled low holding register is discarded.
- **`reset` mid-transfer:** immediately returns to IDLE with all outputs 0. No further OAM writes occur.
- **Index width:** 8 bits, never wraps, because `BYTES` ≤ 256.

## Timing
- `reg_write` sampled high at edge T:
  - `dma_active` = 1 from cycle T+1.
  - START covers cycles T+1..T+4.
- Byte i slot: cycles T+5+4i .. T+8+4i. `dma_src_addr` is stable for the whole slot; data is sampled at T+8+4i.
  - The source must return data within 3 cycles of the address (synchronous RAM with 1-cycle latency is fine).
- Word k write (`oam_write`=1): cycle T+13+8k.
  - Last word (k=79): cycle T+645.
  - `dma_active` = 0 from T+646. Total active time is 645 cycles.
- Outside the write cycles: `oam_write` = 0, and `oam_addr` / `oam_d_wr` hold their last values.
- `dma_src_addr` outside XFER is don't-care; drive 0.

## Structure
- Shared PPU package (alongside `lcdc_t`, `ppu_reg_t`):
  - `oam_dma_state_t` enum {DMA_IDLE, DMA_START, DMA_XFER, DMA_FLUSH}.
  - Constants `OAM_BYTES` = 160 and `OAM_WORDS` = 80.
- Single flat module, no sub-modules. Contents:
  - Phase counter, width $clog2(`CYCLES_PER_BYTE`).
  - Byte index, page register, low holding register, output word register.
- Instantiated in `ppu_m`:
  - Its OAM outputs are muxed ahead of the bus OAM port whenever `dma_active` is high.
  - `reg_write` is qualified by the $FF46 decode.

## Test plan
- **Basic copy:** source $C000..$C09F = i^8'h5A; write 8'hC0.
  - First read address $C000 at T+5.
  - Word 0 = {8'h5B, 8'h5A} written to addr 0 at T+13; word 79 to addr 79 at T+645.
  - `dma_active` high exactly T+1..T+645.
- **Echo remap:** write 8'hE3 → `dma_src_addr` runs $C300..$C39F; `reg_d_rd` reads 8'hE3. Write 8'hFF → addresses $DF00..$DF9F.
- **Restart:** write 8'hC0, then 8'hD0 at T+100.
  - `dma_active` never drops.
  - No writes between T+101 and T+112; the next write is word 0 from $D000/$D001 at T+113.
  - All 80 words end up from $D0xx; done at T+745.
- **Reset mid-transfer:** assert `reset` at T+300.
  - Next cycle: `dma_active` = 0, `oam_write` = 0, `reg_d_rd` = 0.
  - No further OAM writes; a new write of 8'hC1 starts cleanly.
- **Parameter sweep:** `CYCLES_PER_BYTE` = 2, `BYTES` = 8.
  - Writes to words 0..3 at T+7+4k.
  - Active cycles T+1..T+19.
- **Back-to-back:** a new write in the cycle after FLUSH (IDLE) restarts with a 1-cycle `dma_active` gap and correct data.
